game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level game controller for the snake game. Sequences game_logic through idle/clear/play/pause/over.
//  Converts per-frame ticks into movement steps with a score-driven speed-up.
//  Filters direction requests and keeps the score for SSEG_Display.
//  Runs in the vga_clk domain, between the input/clock modules and game_logic.
// PARAMETERS
//  PERIOD_INIT   8   frame ticks per step after a game starts
//  PERIOD_MIN    2   fastest step period, in frame ticks
//  SPEEDUP_EVERY 4   foods eaten per one-tick period decrement
//  CLEAR_CYCLES  16  clk cycles logic_clear is held in CLEAR
//  SCORE_W       8   score width
// PORTS
//  clk          in   1        vga_clk, 25 MHz
//  rst          in   1        asynchronous, active-low reset
//  frame_tick   in   1        1-cycle pulse, once per VGA frame
//  btn_start    in   1        raw level, asynchronous to clk
//  btn_pause    in   1        raw level, asynchronous to clk
//  dir_valid    in   1        dir_req valid this cycle
//  dir_req      in   2        00 up, 01 down, 10 left, 11 right
//  collision    in   1        game_logic: head hit wall/body (pulse or level)
//  food_eaten   in   1        game_logic: 1-cycle pulse
//  step_en      out  1        1-cycle pulse: game_logic advances one move
//  logic_clear  out  1        game_logic synchronous clear
//  dir_out      out  2        committed direction used by the step
//  score        out  SCORE_W  foods eaten, saturating
//  state        out  3        IDLE=0 CLEAR=1 PLAY=2 PAUSE=3 OVER=4
//  game_over    out  1        high while in OVER
// BEHAVIOUR
//  - rst low, asynchronous: state=IDLE, step_en=0, logic_clear=0, dir_out=11, score=0, game_over=0,
//    period=PERIOD_INIT, frame count=0, food count=0, pending dir=11, sync flops=0.
//  - Buttons: 2-FF synchronizer, then rising-edge detect. The press pulse (start_p/pause_p) appears
//    3 clk after the raw edge. A held button yields exactly one pulse.
//  - IDLE: start_p -> CLEAR. Other inputs are ignored.
//  - CLEAR: logic_clear=1 for exactly CLEAR_CYCLES cycles. On entry: score=0, period=PERIOD_INIT,
//    dir_out=pending=11, frame count=0, food count=0. After the last cycle -> PLAY.
//  - PLAY:
//    - Each frame_tick increments the frame count.
//    - The tick that brings the count to period: count <- 0, step_en=1 on the next cycle,
//      and dir_out <- pending in that same cycle.
//    - collision -> OVER. step_en is not issued in, or after, the collision cycle.
//    - pause_p -> PAUSE.
//    - food_eaten: score+1, saturating at 2^SCORE_W-1. Food count +1.
//      At SPEEDUP_EVERY: food count <- 0, period <- max(period-1, PERIOD_MIN).
//  - PAUSE: frame count, pending dir and period are frozen. frame_tick, food and collision are
//    ignored. pause_p -> PLAY; the count resumes from its held value.
//  - OVER: game_over=1, outputs frozen. start_p -> CLEAR.
//  - Direction filter (PLAY only):
//    - Opposite of dir_out means same bit1, different bit0. Such requests are dropped.
//    - Otherwise pending <- dir_req; the last request before a step wins.
//    - A request in the step_en cycle itself applies at the next step.
//  - Simultaneous events:
//    - collision+food in one cycle: OVER, score unchanged.
//    - collision+pause_p: OVER.
//    - start_p in PLAY/PAUSE: ignored.
//  - step_en and logic_clear are never high together. step_en is registered (latency 1 from tick).
//  - rst asserted mid-game: immediate return to reset values, with no spurious step_en on release.
// STRUCTURE
//  - Shared include game_defs.vh holds:
//    - direction codes DIR_UP/DOWN/LEFT/RIGHT;
//    - state codes S_IDLE..S_OVER;
//    - an opposite-direction macro used by direction_input and game_logic.
//  - One sub-module, btn_edge (2-FF sync + rising-edge pulse, rst async low), instantiated twice.
//  - Main FSM, the period/frame counters, and the score/food counters live in this block.
// TESTING
//  1. Reset, then btn_start high 5 clk -> one start_p; logic_clear high 16 cycles; state=2.
//     step_en once per 8 frame_ticks, 1 clk after the 8th tick.
//  2. PLAY with dir_out=11: request 10 -> dropped, dir_out stays 11. Request 00, then 01,
//     both before the step -> dir_out=01 at the next step_en.
//  3. 4 food_eaten pulses -> score=4, period=7. After 24 foods -> period=2 and stays 2.
//     Preload score 255 + food -> stays 255.
//  4. Pause after 5 ticks; 20 ticks while paused -> no step_en. Unpause; 3 ticks -> step_en.
//  5. collision and food_eaten in the same cycle at score=3 -> state=4, game_over=1, score=3,
//     no later step_en. start_p -> CLEAR, score=0.
//  6. rst low mid-PLAY, between a tick and its step_en -> all outputs at reset values
//     asynchronously; no step_en after release.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared codes for the snake game controller: FSM states, the direction codes
// and the opposite-direction test used by the direction filter.
package game_sequencer_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } game_state_t;

    // Opposite directions share the axis bit (bit1) and differ in the sign bit (bit0).
    function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/game_sequencer_btn_edge.sv
// Two-flop synchronizer for a raw push-button followed by a registered
// rising-edge detector; the press pulse appears three clocks after the raw edge.
module game_sequencer_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic sync_1;
    logic sync_2;
    logic sync_2_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            sync_2_d <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync_1   <= btn;
            sync_2   <= sync_1;
            sync_2_d <= sync_2;
            press    <= sync_2 & ~sync_2_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Snake game controller: sequences idle/clear/play/pause/over, turns frame ticks
// into movement steps with a score-driven speed-up, filters turns, keeps score.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int PERIOD_INIT   = 8,
    parameter int PERIOD_MIN    = 2,
    parameter int SPEEDUP_EVERY = 4,
    parameter int CLEAR_CYCLES  = 16,
    parameter int SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               dir_valid,
    input  logic [1:0]         dir_req,
    input  logic               collision,
    input  logic               food_eaten,
    output logic               step_en,
    output logic               logic_clear,
    output logic [1:0]         dir_out,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         state,
    output logic               game_over
);

    localparam int PERIOD_W = $clog2(PERIOD_INIT + 1);
    localparam int CLEAR_W  = $clog2(CLEAR_CYCLES);
    localparam int FOOD_W   = $clog2(SPEEDUP_EVERY);

    game_state_t         state_q;
    game_state_t         state_nxt;
    logic                start_p;
    logic                pause_p;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] frame_cnt;
    logic [CLEAR_W-1:0]  clear_cnt;
    logic [FOOD_W-1:0]   food_cnt;
    logic [1:0]          pending;
    logic [1:0]          pending_nxt;
    logic                enter_clear;
    logic                play_live;
    logic                tick_step;

    game_sequencer_btn_edge u_start (.clk(clk), .rst(rst), .btn(btn_start), .press(start_p));
    game_sequencer_btn_edge u_pause (.clk(clk), .rst(rst), .btn(btn_pause), .press(pause_p));

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (start_p) state_nxt = S_CLEAR;
            S_CLEAR: if (clear_cnt == CLEAR_W'(CLEAR_CYCLES - 1)) state_nxt = S_PLAY;
            S_PLAY: begin
                if (collision)    state_nxt = S_OVER;
                else if (pause_p) state_nxt = S_PAUSE;
            end
            S_PAUSE: if (pause_p) state_nxt = S_PLAY;
            S_OVER:  if (start_p) state_nxt = S_CLEAR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A collision cycle is dead: no counting, no score, no turn, no step.
    always_comb begin
        enter_clear = start_p && (state_q == S_IDLE || state_q == S_OVER);
        play_live   = (state_q == S_PLAY) && !collision;
        tick_step   = play_live && frame_tick && ((frame_cnt + 1'b1) == period);
        pending_nxt = pending;
        if (play_live && dir_valid && !is_opposite(dir_req, dir_out))
            pending_nxt = dir_req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            step_en   <= 1'b0;
            dir_out   <= DIR_RIGHT;
            pending   <= DIR_RIGHT;
            score     <= '0;
            period    <= PERIOD_W'(PERIOD_INIT);
            frame_cnt <= '0;
            clear_cnt <= '0;
            food_cnt  <= '0;
        end else begin
            state_q <= state_nxt;
            step_en <= tick_step;
            if (state_q == S_CLEAR) clear_cnt <= clear_cnt + 1'b1;
            else                    clear_cnt <= '0;

            if (enter_clear) begin
                score     <= '0;
                period    <= PERIOD_W'(PERIOD_INIT);
                dir_out   <= DIR_RIGHT;
                pending   <= DIR_RIGHT;
                frame_cnt <= '0;
                food_cnt  <= '0;
            end else if (play_live) begin
                pending <= pending_nxt;
                if (tick_step) begin
                    frame_cnt <= '0;
                    dir_out   <= pending_nxt;
                end else if (frame_tick) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
                if (food_eaten) begin
                    if (score != '1) score <= score + 1'b1;
                    if (food_cnt == FOOD_W'(SPEEDUP_EVERY - 1)) begin
                        food_cnt <= '0;
                        if (period > PERIOD_W'(PERIOD_MIN)) period <= period - 1'b1;
                    end else begin
                        food_cnt <= food_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign logic_clear = (state_q == S_CLEAR);
    assign game_over   = (state_q == S_OVER);
    assign state       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: start/clear, step timing, turn filtering,
// speed-up and score saturation, pause, collision and mid-game reset.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_req = 2'b00;
    logic       collision = 1'b0;
    logic       food_eaten = 1'b0;
    logic       step_en;
    logic       logic_clear;
    logic [1:0] dir_out;
    logic [7:0] score;
    logic [2:0] state;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    int stray  = 0;
    int n_steps;
    int lc_cnt;

    game_sequencer dut (
        .clk(clk), .rst(rst_n), .frame_tick(frame_tick), .btn_start(btn_start),
        .btn_pause(btn_pause), .dir_valid(dir_valid), .dir_req(dir_req),
        .collision(collision), .food_eaten(food_eaten), .step_en(step_en),
        .logic_clear(logic_clear), .dir_out(dir_out), .score(score),
        .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n frame ticks spaced two cycles apart; counts step_en seen right after a tick.
    task automatic frames(input int n, output int steps);
        steps = 0;
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (step_en) steps++;
            step();
            if (step_en) stray++;
        end
    endtask

    task automatic food(input int n);
        for (int i = 0; i < n; i++) begin
            food_eaten = 1'b1;
            step();
            food_eaten = 1'b0;
            step();
        end
    endtask

    task automatic request(input logic [1:0] d);
        dir_valid = 1'b1;
        dir_req   = d;
        step();
        dir_valid = 1'b0;
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        repeat (5) step();
        btn_start = 1'b0;
        step();
    endtask

    task automatic press_pause();
        btn_pause = 1'b1;
        repeat (5) step();
        btn_pause = 1'b0;
        step();
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (state == s) break;
            step();
        end
        check(tag, state, s);
    endtask

    initial begin
        // Reset values
        repeat (3) step();
        check("rst_state", state, 0);
        check("rst_dir", dir_out, 3);
        check("rst_score", score, 0);
        check("rst_step", step_en, 0);
        check("rst_clear", logic_clear, 0);
        check("rst_over", game_over, 0);
        rst_n = 1'b1;
        step();

        // Start: one press, logic_clear for 16 cycles, then PLAY
        lc_cnt = 0;
        btn_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (logic_clear) lc_cnt++;
            if (i == 2) check("start_latency", state, 0);
        end
        btn_start = 1'b0;
        for (int i = 0; i < 40 && state != 3'd2; i++) begin
            step();
            if (logic_clear) lc_cnt++;
        end
        check("clear_len", lc_cnt, 16);
        check("play_after_clear", state, 2);
        check("score_clear", score, 0);
        frames(7, n_steps);
        check("step_before_8", n_steps, 0);
        frames(1, n_steps);
        check("step_at_8", n_steps, 1);

        // Direction filter
        request(2'b10);
        frames(8, n_steps);
        check("opp_dropped", dir_out, 3);
        request(2'b00);
        request(2'b01);
        check("dir_held_until_step", dir_out, 3);
        frames(8, n_steps);
        check("last_req_wins", dir_out, 1);
        check("dir_step_cnt", n_steps, 1);
        frames(7, n_steps);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("step_cycle_pulse", step_en, 1);
        request(2'b10);
        check("step_cycle_req_late", dir_out, 1);
        frames(8, n_steps);
        check("step_cycle_req_next", dir_out, 2);

        // Pause
        frames(5, n_steps);
        press_pause();
        check("paused", state, 3);
        frames(20, n_steps);
        check("no_step_paused", n_steps, 0);
        press_pause();
        check("unpaused", state, 2);
        frames(2, n_steps);
        check("resume_early", n_steps, 0);
        frames(1, n_steps);
        check("resume_step", n_steps, 1);

        // Speed-up and score saturation
        food(4);
        check("score_4", score, 4);
        frames(6, n_steps);
        check("period7_early", n_steps, 0);
        frames(1, n_steps);
        check("period7_step", n_steps, 1);
        food(20);
        frames(1, n_steps);
        check("period2_early", n_steps, 0);
        frames(1, n_steps);
        check("period2_step", n_steps, 1);
        food(231);
        check("score_255", score, 255);
        food(1);
        check("score_sat", score, 255);
        frames(2, n_steps);
        check("period_min_held", n_steps, 1);

        // Collision, restart, collision together with food
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("over_state", state, 4);
        check("over_score", score, 255);
        press_start();
        check("restart_clear", logic_clear, 1);
        check("restart_score", score, 0);
        wait_state("replay", 3'd2, 40);
        food(3);
        frames(7, n_steps);
        collision  = 1'b1;
        food_eaten = 1'b1;
        frame_tick = 1'b1;
        step();
        collision  = 1'b0;
        food_eaten = 1'b0;
        frame_tick = 1'b0;
        check("coll_food_state", state, 4);
        check("coll_food_over", game_over, 1);
        check("coll_food_score", score, 3);
        check("coll_no_step", step_en, 0);
        frames(10, n_steps);
        check("over_no_step", n_steps, 0);
        check("over_dir_frozen", dir_out, 3);
        press_start();
        check("restart2_score", score, 0);
        check("restart2_over", game_over, 0);

        // Asynchronous reset between a tick and its step
        wait_state("replay2", 3'd2, 40);
        food(1);
        request(2'b00);
        frames(8, n_steps);
        check("pre_rst_dir", dir_out, 0);
        frames(7, n_steps);
        frame_tick = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_score", score, 0);
        check("arst_dir", dir_out, 3);
        check("arst_step", step_en, 0);
        check("arst_over", game_over, 0);
        frame_tick = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_steps = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (step_en) n_steps++;
        end
        check("no_step_after_rst", n_steps, 0);
        check("idle_after_rst", state, 0);
        check("no_stray_step", stray, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
